switch_debouncer: RTL
=====================

Name: switch_debouncer

Overview:
- Upstream input-conditioning stage for the slide-switch inputs of the lights FSMs (e.g. the sw1/sw0 mode select of the hazard-light block).
- Synchronises asynchronous SW bits into the FSM clock domain and debounces them against a slow tick enable.
- Emits clean, glitch-free levels plus a one-cycle change pulse per bit, so downstream FSMs never see metastable or chattering mode inputs.

Parameters:
- WIDTH, 2, number of independent switch bits conditioned.
- STABLE_CNT, 4, consecutive tick_en cycles a synchronised bit must differ from its clean value before the clean value updates; legal range 1..255.

Ports:
- clk  input  1  FSM clock (a clock_divider output bit).
- reset  input  1  synchronous, active-high reset.
- tick_en  input  1  sample-enable strobe; debounce counting advances only on cycles where it is 1.
- sw_raw  input  WIDTH  asynchronous switch levels.
- sw_clean  output  WIDTH  debounced switch levels.
- sw_changed  output  WIDTH  one-cycle pulse per bit when sw_clean[i] updates.

Behaviour:
- Reset (sampled on posedge clk while reset=1): both synchroniser stages = 0, sw_clean = 0, sw_changed = 0, all counters = 0. Reset overrides every other update in the same cycle.
- Reset mid-debounce discards partial counts.
- Synchroniser: two flops per bit, s1 <= sw_raw, s2 <= s1. s2 is the only value the debounce logic uses.
- Per-bit counter cnt[i], width max(1, $clog2(STABLE_CNT)), evaluated each posedge clk:
  - s2[i] == sw_clean[i] (any cycle, tick or not): cnt[i] <= 0.
  - Mismatch, tick_en=0: cnt[i] holds.
  - Mismatch, tick_en=1, cnt[i] < STABLE_CNT-1: cnt[i] <= cnt[i]+1.
  - Mismatch, tick_en=1, cnt[i] == STABLE_CNT-1: sw_clean[i] <= s2[i], cnt[i] <= 0, sw_changed[i] <= 1.
- sw_changed[i] = 0 in every other cycle. It is high exactly one cycle, coincident with the first cycle of the new sw_clean value.
- Latency with tick_en held at 1: a raw edge captured at posedge k appears on sw_clean after posedge k+1+STABLE_CNT, i.e. 2+STABLE_CNT-1 further edges.
- STABLE_CNT = 1: update on the first mismatching tick.
- Glitch rule: any single cycle in which s2 matches sw_clean restarts the count from 0. A glitch shorter than STABLE_CNT ticks never reaches sw_clean.
- Bits are fully independent. Simultaneous updates on several bits assert the corresponding sw_changed bits in the same cycle.
- Counter saturation cannot occur: the counter always clears on reaching STABLE_CNT-1 with a tick.

Optional Feature:
- Macro: SWDB_BYPASS_EN.
- Defined: the debounce counters are removed. sw_clean <= s2 every cycle, regardless of tick_en. sw_changed[i] pulses for one cycle whenever s2[i] != sw_clean[i]. The synchroniser is retained and reset behaviour is unchanged. Used for fast simulation of downstream FSMs.
- Undefined: full debounce behaviour as above.

Test Plan:
- Reset: assert reset for 2 cycles with sw_raw=2'b11 -> sw_clean=2'b00, sw_changed=2'b00 throughout reset and on the first cycle after release.
- Clean rise: STABLE_CNT=4, tick_en=1, sw_raw[0] 0->1 before posedge 0 -> sw_clean[0]=1 and sw_changed[0]=1 after posedge 5 only; sw_changed[0]=0 after posedge 6.
- Glitch reject: sw_raw[1] high for 3 cycles then low, tick_en=1, STABLE_CNT=4 -> sw_clean[1] stays 0, sw_changed[1] never asserts.
- Tick gating: tick_en pulses every 4th cycle, sw_raw=2'b10 held -> sw_clean[1] rises after the 4th post-sync tick, i.e. about 16 cycles later; cnt holds between ticks.
- Simultaneous: sw_raw 2'b00->2'b11 in one cycle -> both bits update and sw_changed=2'b11 in the same cycle.
- Reset mid-count: assert reset when cnt[0]=2, release, keep sw_raw[0]=1 -> a full STABLE_CNT ticks is required after re-synchronisation before sw_clean[0]=1.

Source files
------------

// File: rtl/switch_debouncer.sv
// Two-flop synchroniser plus per-bit tick-gated debounce counter for slide-switch inputs.
// Define SWDB_BYPASS_EN to drop the counters and pass the synchronised levels straight through.
module switch_debouncer #(
  parameter int WIDTH      = 2,
  parameter int STABLE_CNT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_en,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_changed
);

  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;

  // Stage p0/p1: metastability filter; only sync_p1 feeds the debounce logic
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= sw_raw;
      sync_p1 <= sync_p0;
    end
  end

`ifdef SWDB_BYPASS_EN

  logic unused_tick;
  assign unused_tick = tick_en;

  // Stage p2: clean level follows the synchroniser every cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_clean   <= '0;
      sw_changed <= '0;
    end else begin
      sw_clean   <= sync_p1;
      sw_changed <= sync_p1 ^ sw_clean;
    end
  end

`else

  localparam int CNT_W = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  logic [CNT_W-1:0] cnt      [WIDTH];
  logic [CNT_W-1:0] cnt_next [WIDTH];
  logic [WIDTH-1:0] clean_next;
  logic [WIDTH-1:0] changed_next;

  always_comb begin
    clean_next   = sw_clean;
    changed_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_next[i] = cnt[i];
      if (sync_p1[i] == sw_clean[i]) begin
        cnt_next[i] = '0;
      end else if (tick_en) begin
        if (cnt[i] == CNT_LAST) begin
          clean_next[i]   = sync_p1[i];
          changed_next[i] = 1'b1;
          cnt_next[i]     = '0;
        end else begin
          cnt_next[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Stage p2: counters and clean level; any matching cycle restarts the count
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_clean   <= '0;
      sw_changed <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      sw_clean   <= clean_next;
      sw_changed <= changed_next;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_next[i];
    end
  end

`endif

endmodule
